// File: rtl/sparse_round_scheduler_if.sv
// rtl/sparse_round_scheduler_if.sv - host, sparse-memory, controller and acc-clear signals of the round scheduler
interface sparse_round_scheduler_if #(
  parameter int WORD_WIDTH = 32
);
  // host side
  logic                  start_i;
  logic [5:0]            weight_count_i;
  logic [5:0]            round_idx_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  // sparse memory (synchronous read, one cycle of latency)
  logic [9:0]            sparse_mem_addr_o;
  logic [WORD_WIDTH-1:0] sparse_mem_data_i;
  // accumulate controller
  logic                  ctrl_start_o;
  logic                  ctrl_busy_i;
  // accumulator clear port
  logic [9:0]            acc_clr_addr_o;
  logic                  acc_clr_we_o;
  logic [WORD_WIDTH-1:0] acc_clr_data_o;

  // environment: host, sparse memory and controller
  modport master (
    output start_i, weight_count_i, sparse_mem_data_i, ctrl_busy_i,
    input  round_idx_o, busy_o, done_o, error_o, sparse_mem_addr_o,
           ctrl_start_o, acc_clr_addr_o, acc_clr_we_o, acc_clr_data_o
  );

  // scheduler
  modport slave (
    input  start_i, weight_count_i, sparse_mem_data_i, ctrl_busy_i,
    output round_idx_o, busy_o, done_o, error_o, sparse_mem_addr_o,
           ctrl_start_o, acc_clr_addr_o, acc_clr_we_o, acc_clr_data_o
  );
endinterface

// File: rtl/sparse_round_scheduler.sv
// rtl/sparse_round_scheduler.sv - sequences one accumulate round per sparse entry; SPARSE_SCHED_ACC_CLEAR_EN adds an accumulator clear pass
module sparse_round_scheduler #(
  parameter int WORD_WIDTH      = 32,
  parameter int MEM_SPARSE_SIZE = 50,
  parameter int MEM_SIZE        = 553,
  parameter int WDOG_CYCLES     = 65535
) (
  input logic                     clk,
  input logic                     rst_n,
  sparse_round_scheduler_if.slave bus
);

  localparam int                    WDOG_W    = $clog2(WDOG_CYCLES + 1);
  localparam logic [5:0]            N_MAX     = 6'(MEM_SPARSE_SIZE);
  localparam logic [WDOG_W-1:0]     WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] SKIP_WORD = '1;

  // Addresses are 10 bits and entry counts 6 bits; anything larger cannot be expressed on the ports.
  if (MEM_SIZE > 1024 || MEM_SIZE < 1 || MEM_SPARSE_SIZE > 63 || MEM_SPARSE_SIZE < 1) begin : g_cfg_check
    $error("sparse_round_scheduler: MEM_SIZE or MEM_SPARSE_SIZE out of range");
  end

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_SET_ADDR,
    S_SETTLE,
    S_ARM,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [5:0]        n_q;
  logic [5:0]        round_idx_q;
  logic [9:0]        addr_q;
  logic              ctrl_start_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [WDOG_W-1:0] wdog_q;
  logic [5:0]        n_clamped;

`ifdef SPARSE_SCHED_ACC_CLEAR_EN
  localparam logic [9:0] CLR_LAST = 10'(MEM_SIZE - 1);
  logic [9:0]        clr_addr_q;
  logic              clr_we_q;
`endif

  // Requested entry count limited to the sparse memory depth
  always_comb begin
    n_clamped = (bus.weight_count_i > N_MAX) ? N_MAX : bus.weight_count_i;
  end

  // Round sequencer: one pass over the entries per accepted start, with a per-round watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      round_idx_q  <= '0;
      addr_q       <= '0;
      ctrl_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      wdog_q       <= '0;
`ifdef SPARSE_SCHED_ACC_CLEAR_EN
      clr_addr_q   <= '0;
      clr_we_q     <= 1'b0;
`endif
    end else begin
      ctrl_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            n_q         <= n_clamped;
            round_idx_q <= '0;
            // The address goes out on entry to SET_ADDR so the memory has
            // already captured it when SETTLE inspects the read data.
            addr_q      <= '0;
            busy_q      <= 1'b1;
            error_q     <= 1'b0;
            if (n_clamped == 6'd0) begin
              state_q <= S_DONE;
            end else begin
`ifdef SPARSE_SCHED_ACC_CLEAR_EN
              clr_addr_q <= '0;
              clr_we_q   <= 1'b1;
              state_q    <= S_CLEAR;
`else
              state_q    <= S_SET_ADDR;
`endif
            end
          end
        end
`ifdef SPARSE_SCHED_ACC_CLEAR_EN
        S_CLEAR: begin
          if (clr_addr_q == CLR_LAST) begin
            clr_we_q <= 1'b0;
            state_q  <= S_SET_ADDR;
          end else begin
            clr_addr_q <= clr_addr_q + 10'd1;
          end
        end
`endif
        S_SET_ADDR: begin
          addr_q  <= {4'd0, round_idx_q};
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          // An all-ones word marks an unused entry: no round is started for it.
          if (bus.sparse_mem_data_i == SKIP_WORD) begin
            state_q <= S_NEXT;
          end else begin
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          ctrl_start_q <= 1'b1;
          wdog_q       <= '0;
          state_q      <= S_WAIT_HI;
        end
        S_WAIT_HI, S_WAIT_LO: begin
          // A round ends on the falling edge of busy; completion wins over a same-cycle timeout.
          wdog_q <= wdog_q + 1'b1;
          if (state_q == S_WAIT_HI && bus.ctrl_busy_i) begin
            state_q <= S_WAIT_LO;
          end else if (state_q == S_WAIT_LO && !bus.ctrl_busy_i) begin
            state_q <= S_NEXT;
          end else if (wdog_q == WDOG_LAST) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_NEXT: begin
          if (round_idx_q == n_q - 6'd1) begin
            state_q <= S_DONE;
          end else begin
            round_idx_q <= round_idx_q + 6'd1;
            addr_q      <= {4'd0, round_idx_q + 6'd1};
            state_q     <= S_SET_ADDR;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sparse_mem_addr_o = addr_q;
  assign bus.ctrl_start_o      = ctrl_start_q;
  assign bus.round_idx_o       = round_idx_q;
  assign bus.busy_o            = busy_q;
  assign bus.done_o            = done_q;
  assign bus.error_o           = error_q;
  assign bus.acc_clr_data_o    = '0;

`ifdef SPARSE_SCHED_ACC_CLEAR_EN
  assign bus.acc_clr_addr_o    = clr_addr_q;
  assign bus.acc_clr_we_o      = clr_we_q;
`else
  assign bus.acc_clr_addr_o    = '0;
  assign bus.acc_clr_we_o      = 1'b0;
`endif

endmodule
